parking_lane_arbiter: RTL and testbench
=======================================

# parking_lane_arbiter

Single-lane gate controller for the parking lot. It shares one physical gate lane between cars entering and cars leaving, and enforces a lot capacity. It grants the lane to one direction at a time with round-robin priority on conflicts, holds the gate open until the car clears or a timeout expires, and maintains the occupancy count that feeds the HEX display decoder. It sits between the passcode checker (which raises `Req_in` only after a valid code) and the gate/display logic.

## Interface
Parameters:
- `CAPACITY`, default 3: maximum cars in the lot; must satisfy 1 ≤ CAPACITY ≤ 2^CW−1.
- `OPEN_CYC`, default 4: maximum cycles a gate stays open waiting for `Car_clear`; must be ≥ 1.
- `CW`, default 2: width of `count`.

Ports (one clock; reset is synchronous and active-high):
- `CLK` in 1: system clock; all state changes on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `Req_in` in 1: car waiting at the entrance with a validated passcode; level, held by the requester.
- `Req_out` in 1: car waiting at the exit; level.
- `Car_clear` in 1: lane sensor; high for ≥1 cycle when a car has passed through the open gate.
- `Entrance` out 1: entrance gate open.
- `Exit` out 1: exit gate open.
- `count` out CW: current occupancy.
- `Full` out 1: `count == CAPACITY`.
- `Busy` out 1: lane granted (state ≠ IDLE).

## Operation
- States:
  - IDLE: lane free.
  - IN_OPEN: `Entrance` = 1.
  - OUT_OPEN: `Exit` = 1.
  - GUARD: both gates closed for one cycle.
- Eligibility:
  - `ein = Req_in && count < CAPACITY`.
  - `eout = Req_out && count > 0`.
  - Ineligible requests are ignored and stay pending; they are not queued.
- IDLE:
  - Only `ein`: go to IN_OPEN.
  - Only `eout`: go to OUT_OPEN.
  - Both: grant the direction opposite to `last_grant`.
  - Neither: stay in IDLE.
  - On any grant, set `last_grant` to the granted direction.
- IN_OPEN / OUT_OPEN:
  - The timer loads 0 on entry and increments each cycle.
  - `Car_clear` high: count +1 (IN) or −1 (OUT), then go to GUARD.
  - Else, if timer == OPEN_CYC−1: go to GUARD with no count change (timeout).
- GUARD: unconditionally go to IDLE.
- `Car_clear` is ignored in IDLE and GUARD.
- `count` never wraps, by construction of the eligibility rules.
- `Entrance` and `Exit` are never high simultaneously.
- `Entrance`, `Exit`, `Full`, and `Busy` are registered (decoded from the state register and `count` only).

## Timing
- Reset: state IDLE, `count` = 0, `last_grant` = EXIT (so the first tie goes to entry), timer = 0.
  - Output reset values: `Entrance` = 0, `Exit` = 0, `Full` = 0, `Busy` = 0.
- Reset mid-operation:
  - Gates close in the cycle after the reset edge.
  - Occupancy is lost (`count` = 0).
  - `RST` dominates all other inputs.
- Grant latency: a request sampled in IDLE at edge k raises the gate from cycle k+1.
- Open duration:
  - With `Car_clear` first sampled high at the j-th open cycle (1 ≤ j ≤ OPEN_CYC), the gate stays high exactly j cycles.
  - `count` updates on the same edge that drops the gate.
- Timeout: the gate stays high exactly OPEN_CYC cycles.
- Turnaround:
  - After the gate drops: one GUARD cycle, then IDLE for ≥1 cycle.
  - Minimum closed gap between two grants is 2 cycles.
- `Car_clear` on the final open cycle counts as a pass, not a timeout.
- `Full` and `count` change on the same edge.

## Test plan
- Reset, then `Req_in` = 1 at cycle 0, `Car_clear` pulse on the 2nd open cycle:
  - `Entrance` high cycles 1–2.
  - `count` 0→1 at the edge ending cycle 2.
  - `Busy` low from cycle 4.
- Fill the lot to `count` = 3, then hold `Req_in` = 1:
  - `Full` = 1; `Entrance` never rises.
  - Assert `Req_out` with a clear: `Exit` grants, `count` = 2, `Full` = 0, then `Entrance` grants after the 2-cycle gap.
- `Req_in` and `Req_out` both high continuously with `count` = 1, clearing each grant:
  - Grants alternate IN, OUT, IN, OUT.
  - First tie after reset goes to IN.
  - `count` oscillates 1↔2.
- `Req_in` with no `Car_clear`:
  - `Entrance` high exactly 4 cycles, `count` unchanged, then GUARD, then a regrant.
- `RST` asserted during OUT_OPEN with `count` = 2:
  - Next cycle `Exit` = 0, `count` = 0, `Busy` = 0.
  - A following `Req_out` is ignored (empty lot).
- `Car_clear` pulsed in IDLE and in GUARD: `count` unchanged.

Source files
------------

// File: rtl/parking_lane_arbiter.sv
// Single-lane gate arbiter: shares one lane between entry and exit traffic,
// round-robin on conflicts, with an open-gate timeout and a capacity limit.
module parking_lane_arbiter #(
    parameter int CAPACITY = 3,
    parameter int OPEN_CYC = 4,
    parameter int CW       = 2
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          Req_in,
    input  logic          Req_out,
    input  logic          Car_clear,
    output logic          Entrance,
    output logic          Exit,
    output logic [CW-1:0] count,
    output logic          Full,
    output logic          Busy
);

    localparam int TW = (OPEN_CYC > 1) ? $clog2(OPEN_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IN_OPEN  = 2'd1,
        OUT_OPEN = 2'd2,
        GUARD    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [CW-1:0] count_q, count_d;
    logic          last_q, last_d;

    logic ein;
    logic eout;
    logic timeout;

    assign ein     = Req_in && (count_q < CW'(CAPACITY));
    assign eout    = Req_out && (count_q != '0);
    assign timeout = (timer_q == TW'(OPEN_CYC - 1));

    // last_q: 1 means the most recent grant was the exit direction
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            timer_q <= '0;
            count_q <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            count_q <= count_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        count_d = count_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                timer_d = '0;
                if (ein && (!eout || last_q)) begin
                    state_d = IN_OPEN;
                    last_d  = 1'b0;
                end else if (eout) begin
                    state_d = OUT_OPEN;
                    last_d  = 1'b1;
                end
            end
            IN_OPEN: begin
                if (Car_clear) begin
                    count_d = count_q + CW'(1);
                    state_d = GUARD;
                end else if (timeout) begin
                    state_d = GUARD;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            OUT_OPEN: begin
                if (Car_clear) begin
                    count_d = count_q - CW'(1);
                    state_d = GUARD;
                end else if (timeout) begin
                    state_d = GUARD;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            GUARD: begin
                state_d = IDLE;
                timer_d = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        Entrance = (state_q == IN_OPEN);
        Exit     = (state_q == OUT_OPEN);
        Busy     = (state_q != IDLE);
        Full     = (count_q == CW'(CAPACITY));
        count    = count_q;
    end

endmodule

// File: tb/tb_parking_lane_arbiter.sv
// Scoreboard bench for parking_lane_arbiter: stimulus pushes the expected
// outputs for the following cycle, a monitor pops and compares them.
module tb_parking_lane_arbiter;

    logic       CLK;
    logic       RST;
    logic       Req_in;
    logic       Req_out;
    logic       Car_clear;
    logic       Entrance;
    logic       Exit;
    logic [1:0] count;
    logic       Full;
    logic       Busy;

    int checks;
    int errors;
    int step_no;
    bit done;

    typedef struct {
        int       id;
        logic [5:0] exp;
    } item_t;

    item_t sbq[$];

    parking_lane_arbiter #(
        .CAPACITY(3),
        .OPEN_CYC(4),
        .CW(2)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .Req_in(Req_in),
        .Req_out(Req_out),
        .Car_clear(Car_clear),
        .Entrance(Entrance),
        .Exit(Exit),
        .count(count),
        .Full(Full),
        .Busy(Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Drive one cycle of inputs; expected values are the outputs seen
    // in the cycle after the rising edge that samples these inputs.
    task automatic step(
        input logic r, input logic ri, input logic ro, input logic c,
        input logic e, input logic x, input logic [1:0] n,
        input logic f, input logic b
    );
        item_t it;
        @(negedge CLK);
        RST       = r;
        Req_in    = ri;
        Req_out   = ro;
        Car_clear = c;
        step_no++;
        it.id  = step_no;
        it.exp = {e, x, n, f, b};
        sbq.push_back(it);
    endtask

    task automatic stimulus();
        // reset, single entry cleared on 2nd open cycle, clears in GUARD/IDLE
        step(1, 0, 0, 0, 0, 0, 2'd0, 0, 0);
        step(0, 1, 0, 0, 1, 0, 2'd0, 0, 1);
        step(0, 0, 0, 0, 1, 0, 2'd0, 0, 1);
        step(0, 0, 0, 1, 0, 0, 2'd1, 0, 1);
        step(0, 0, 0, 1, 0, 0, 2'd1, 0, 0);
        step(0, 0, 0, 1, 0, 0, 2'd1, 0, 0);
        // fill to capacity
        step(0, 1, 0, 0, 1, 0, 2'd1, 0, 1);
        step(0, 0, 0, 1, 0, 0, 2'd2, 0, 1);
        step(0, 0, 0, 0, 0, 0, 2'd2, 0, 0);
        step(0, 1, 0, 0, 1, 0, 2'd2, 0, 1);
        step(0, 0, 0, 1, 0, 0, 2'd3, 1, 1);
        step(0, 0, 0, 0, 0, 0, 2'd3, 1, 0);
        // full: entry request ignored
        step(0, 1, 0, 0, 0, 0, 2'd3, 1, 0);
        step(0, 1, 0, 0, 0, 0, 2'd3, 1, 0);
        step(0, 1, 0, 0, 0, 0, 2'd3, 1, 0);
        // exit frees a slot, entry granted after the 2-cycle gap
        step(0, 1, 1, 0, 0, 1, 2'd3, 1, 1);
        step(0, 1, 0, 1, 0, 0, 2'd2, 0, 1);
        step(0, 1, 0, 0, 0, 0, 2'd2, 0, 0);
        step(0, 1, 0, 0, 1, 0, 2'd2, 0, 1);
        step(0, 0, 0, 1, 0, 0, 2'd3, 1, 1);
        step(0, 0, 0, 0, 0, 0, 2'd3, 1, 0);
        // reset, then build count=1 with last grant = exit
        step(1, 0, 0, 0, 0, 0, 2'd0, 0, 0);
        step(0, 1, 0, 0, 1, 0, 2'd0, 0, 1);
        step(0, 0, 0, 1, 0, 0, 2'd1, 0, 1);
        step(0, 0, 0, 0, 0, 0, 2'd1, 0, 0);
        step(0, 1, 0, 0, 1, 0, 2'd1, 0, 1);
        step(0, 0, 0, 1, 0, 0, 2'd2, 0, 1);
        step(0, 0, 0, 0, 0, 0, 2'd2, 0, 0);
        step(0, 0, 1, 0, 0, 1, 2'd2, 0, 1);
        step(0, 0, 0, 1, 0, 0, 2'd1, 0, 1);
        step(0, 0, 0, 0, 0, 0, 2'd1, 0, 0);
        // continuous tie: IN, OUT, IN, OUT
        for (int k = 0; k < 2; k++) begin
            step(0, 1, 1, 0, 1, 0, 2'd1, 0, 1);
            step(0, 1, 1, 1, 0, 0, 2'd2, 0, 1);
            step(0, 1, 1, 0, 0, 0, 2'd2, 0, 0);
            step(0, 1, 1, 0, 0, 1, 2'd2, 0, 1);
            step(0, 1, 1, 1, 0, 0, 2'd1, 0, 1);
            step(0, 1, 1, 0, 0, 0, 2'd1, 0, 0);
        end
        // timeout: gate open exactly 4 cycles, count unchanged, regrant
        step(0, 1, 0, 0, 1, 0, 2'd1, 0, 1);
        step(0, 1, 0, 0, 1, 0, 2'd1, 0, 1);
        step(0, 1, 0, 0, 1, 0, 2'd1, 0, 1);
        step(0, 1, 0, 0, 1, 0, 2'd1, 0, 1);
        step(0, 1, 0, 0, 0, 0, 2'd1, 0, 1);
        step(0, 1, 0, 0, 0, 0, 2'd1, 0, 0);
        step(0, 1, 0, 0, 1, 0, 2'd1, 0, 1);
        // clear on final open cycle counts as a pass
        step(0, 0, 0, 0, 1, 0, 2'd1, 0, 1);
        step(0, 0, 0, 0, 1, 0, 2'd1, 0, 1);
        step(0, 0, 0, 0, 1, 0, 2'd1, 0, 1);
        step(0, 0, 0, 1, 0, 0, 2'd2, 0, 1);
        step(0, 0, 0, 0, 0, 0, 2'd2, 0, 0);
        // reset during OUT_OPEN, then exit request on empty lot ignored
        step(0, 0, 1, 0, 0, 1, 2'd2, 0, 1);
        step(1, 1, 1, 1, 0, 0, 2'd0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 2'd0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 2'd0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 2'd0, 0, 0);
        done = 1'b1;
    endtask

    task automatic monitor();
        item_t      it;
        logic [5:0] act;
        int         cyc;
        cyc = 0;
        while (!(done && sbq.size() == 0)) begin
            @(posedge CLK);
            #1;
            cyc++;
            if (cyc > 1000) begin
                errors++;
                $display("FAIL timeout: %0d items left, want 0", sbq.size());
                break;
            end
            if (sbq.size() != 0) begin
                it  = sbq.pop_front();
                act = {Entrance, Exit, count, Full, Busy};
                checks++;
                if (act !== it.exp) begin
                    errors++;
                    $display("FAIL step%0d {ent,exit,count,full,busy}: got %b want %b",
                             it.id, act, it.exp);
                end
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        step_no   = 0;
        done      = 1'b0;
        RST       = 1'b1;
        Req_in    = 1'b0;
        Req_out   = 1'b0;
        Car_clear = 1'b0;
        fork
            stimulus();
            monitor();
        join
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
